// File: rtl/chip_top_1127a0_pkg.sv
// Shared types and constants for the 1127a0 pad-control / test-mode wrapper.
package chip_top_1127a0_pkg;

   localparam int unsigned NPAD        = 9;
   localparam int unsigned KEY_W       = 8;
   localparam int unsigned KEY_CNT_W   = 3;
   localparam int unsigned DEB_DEFAULT = 4;
   localparam logic [KEY_W-1:0] KEY_DEFAULT = 8'hA5;

   localparam int unsigned PAD_TST     = 0;
   localparam int unsigned PAD_GPIO_TS = 1;
   localparam int unsigned PAD_SCL     = 2;
   localparam int unsigned PAD_SDA     = 3;
   localparam int unsigned PAD_GPIO1   = 4;
   localparam int unsigned PAD_GPIO2   = 5;
   localparam int unsigned PAD_GPIO3   = 6;
   localparam int unsigned PAD_GPIO4   = 7;
   localparam int unsigned PAD_GPIO5   = 8;

   typedef enum logic [1:0] {
      ST_FUNC = 2'd0,
      ST_KEY  = 2'd1,
      ST_SCAN = 2'd2,
      ST_LOCK = 2'd3
   } state_e;

endpackage

// File: rtl/chip_top_1127a0_if.sv
// Pad, core and scan signal bundle between the pad ring/core and the wrapper.
interface chip_top_1127a0_if;
   import chip_top_1127a0_pkg::*;

   logic [NPAD-1:0] pad_di;
   logic [NPAD-1:0] pad_do;
   logic [NPAD-1:0] pad_oe;
   logic [NPAD-1:0] func_do;
   logic [NPAD-1:0] func_oe;
   logic [NPAD-1:0] func_di;
   logic [1:0]      scan_so;
   logic [1:0]      scan_si;
   logic            scan_en;
   logic            scan_clk;
   logic            scan_mode;
   logic [1:0]      mode;

   modport master (
      output pad_di, func_do, func_oe, scan_so,
      input  pad_do, pad_oe, func_di, scan_si, scan_en, scan_clk, scan_mode, mode
   );

   modport slave (
      input  pad_di, func_do, func_oe, scan_so,
      output pad_do, pad_oe, func_di, scan_si, scan_en, scan_clk, scan_mode, mode
   );

endinterface

// File: rtl/chip_top_1127a0_pad_sync_deb.sv
// Two-flop synchronizer with optional DEB-cycle debouncer (DEB=0 bypasses it).
module chip_top_1127a0_pad_sync_deb #(
   parameter int unsigned DEB = 4
) (
   input  logic clk,
   input  logic rstz,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   generate
      if (DEB == 0) begin : g_bypass
         assign q_o = sync_q;
      end else begin : g_deb
         localparam int unsigned CW = 4;
         logic [CW-1:0] cnt_q, cnt_d;
         logic          deb_q, deb_d;

         // Output flips once the input has disagreed for DEB consecutive cycles.
         always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (sync_q != deb_q) begin
               if (cnt_q == CW'(DEB - 1)) begin
                  deb_d = sync_q;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         always_ff @(posedge clk or negedge rstz) begin
            if (!rstz) begin
               cnt_q <= '0;
               deb_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               deb_q <= deb_d;
            end
         end

         assign q_o = deb_q;
      end
   endgenerate

endmodule

// File: rtl/chip_top_1127a0.sv
// Pad-control and test-mode wrapper: key-gated entry into ATPG scan pad muxing.
module chip_top_1127a0
   import chip_top_1127a0_pkg::*;
#(
   parameter logic [KEY_W-1:0] KEY = KEY_DEFAULT,
   parameter int unsigned      DEB = DEB_DEFAULT
) (
   input  logic               clk,
   input  logic               rstz,
   chip_top_1127a0_if.slave   bus
);

   logic tst_s, scl_s, sda_s;
   logic scl_prev_q;
   logic scl_rise;

   state_e                 state_q, state_d;
   logic [KEY_W-1:0]       sh_q, sh_d;
   logic [KEY_CNT_W-1:0]   cnt_q, cnt_d;
   logic                   scan_mode_q;

   chip_top_1127a0_pad_sync_deb #(.DEB(DEB)) u_tst (
      .clk (clk), .rstz (rstz), .d_i (bus.pad_di[PAD_TST]), .q_o (tst_s)
   );

   chip_top_1127a0_pad_sync_deb #(.DEB(0)) u_scl (
      .clk (clk), .rstz (rstz), .d_i (bus.pad_di[PAD_SCL]), .q_o (scl_s)
   );

   chip_top_1127a0_pad_sync_deb #(.DEB(0)) u_sda (
      .clk (clk), .rstz (rstz), .d_i (bus.pad_di[PAD_SDA]), .q_o (sda_s)
   );

   assign scl_rise = scl_s & ~scl_prev_q;

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q     <= ST_FUNC;
         sh_q        <= '0;
         cnt_q       <= '0;
         scl_prev_q  <= 1'b0;
         scan_mode_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         scl_prev_q  <= scl_s;
         scan_mode_q <= (state_d == ST_SCAN);
      end
   end

   // Key capture; a low debounced TST overrides every other transition.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_FUNC: begin
            sh_d  = '0;
            cnt_d = '0;
            if (tst_s) state_d = ST_KEY;
         end
         ST_KEY: begin
            if (scl_rise) begin
               sh_d  = KEY_W'({sh_q, sda_s});
               cnt_d = cnt_q + KEY_CNT_W'(1);
               if (cnt_q == KEY_CNT_W'(KEY_W - 1)) begin
                  state_d = (sh_d == KEY) ? ST_SCAN : ST_LOCK;
               end
            end
         end
         default: ;
      endcase
      if (!tst_s) state_d = ST_FUNC;
   end

   logic            in_scan;
   logic [NPAD-1:0] pad_do_c, pad_oe_c, func_di_c;

   assign in_scan = (state_q == ST_SCAN);

   // Pad muxing follows the state register directly so reset reverts it at once.
   always_comb begin
      pad_do_c  = bus.func_do;
      pad_oe_c  = bus.func_oe;
      func_di_c = bus.pad_di;
      if (in_scan) begin
         pad_oe_c             = '0;
         pad_oe_c[PAD_GPIO4]  = 1'b1;
         pad_oe_c[PAD_GPIO5]  = 1'b1;
         pad_do_c[PAD_GPIO4]  = bus.scan_so[0];
         pad_do_c[PAD_GPIO5]  = bus.scan_so[1];
         func_di_c[PAD_GPIO_TS] = 1'b0;
         func_di_c[PAD_GPIO5:PAD_GPIO1] = '0;
      end
      pad_oe_c[PAD_TST] = 1'b0;
   end

   assign bus.pad_do    = pad_do_c;
   assign bus.pad_oe    = pad_oe_c;
   assign bus.func_di   = func_di_c;
   assign bus.scan_en   = in_scan & bus.pad_di[PAD_GPIO1];
   assign bus.scan_si   = {in_scan & bus.pad_di[PAD_GPIO3], in_scan & bus.pad_di[PAD_GPIO2]};
   assign bus.scan_clk  = in_scan & bus.pad_di[PAD_GPIO_TS];
   assign bus.scan_mode = scan_mode_q;
   assign bus.mode      = 2'(state_q);

endmodule

// File: tb/tb_chip_top_1127a0.sv
// Directed self-checking bench for chip_top_1127a0: pad muxing tables plus key-entry sequences.
module tb_chip_top_1127a0;
   import chip_top_1127a0_pkg::*;

   logic clk  = 1'b0;
   logic rstz = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   chip_top_1127a0_if bus ();

   chip_top_1127a0 #(.KEY(8'hA5), .DEB(4)) dut (
      .clk  (clk),
      .rstz (rstz),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] di;
      logic [8:0] fdo;
      logic [8:0] foe;
      logic [1:0] so;
      logic [8:0] e_do;
      logic [8:0] e_oe;
      logic [8:0] e_di;
      logic       e_en;
      logic [1:0] e_si;
      logic       e_clk;
   } vec_t;

   vec_t func_tbl[3];
   vec_t scan_tbl[3];

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input string tag, input vec_t v);
      bus.pad_di  = v.di;
      bus.func_do = v.fdo;
      bus.func_oe = v.foe;
      bus.scan_so = v.so;
      #1;
      chk({tag, "_pad_do"},   bus.pad_do,            v.e_do);
      chk({tag, "_pad_oe"},   bus.pad_oe,            v.e_oe);
      chk({tag, "_func_di"},  bus.func_di,           v.e_di);
      chk({tag, "_scan_en"},  9'(bus.scan_en),       9'(v.e_en));
      chk({tag, "_scan_si"},  9'(bus.scan_si),       9'(v.e_si));
      chk({tag, "_scan_clk"}, 9'(bus.scan_clk),      9'(v.e_clk));
   endtask

   // Debounced TST needs DEB+2 edges, the FSM one more.
   task automatic wait_key_entry(input string tag);
      tick(6);
      chk({tag, "_mode_before_deb"}, 9'(bus.mode), 9'd0);
      tick(1);
      chk({tag, "_mode_key"}, 9'(bus.mode), 9'd1);
   endtask

   task automatic drop_tst(input string tag, input logic [1:0] cur_mode);
      bus.pad_di[PAD_TST] = 1'b0;
      tick(6);
      chk({tag, "_mode_hold"}, 9'(bus.mode), 9'(cur_mode));
      tick(1);
      chk({tag, "_mode_func"}, 9'(bus.mode), 9'd0);
   endtask

   task automatic shift_key(input string tag, input logic [7:0] k,
                            input logic [1:0] pre_mode, input logic [1:0] post_mode);
      for (int i = 7; i >= 0; i--) begin
         bus.pad_di[PAD_SCL] = 1'b0;
         bus.pad_di[PAD_SDA] = k[i];
         tick(3);
         bus.pad_di[PAD_SCL] = 1'b1;
         tick(2);
         if (i == 0) chk({tag, "_mode_pre"}, 9'(bus.mode), 9'(pre_mode));
         tick(1);
      end
      chk({tag, "_mode_post"}, 9'(bus.mode), 9'(post_mode));
      bus.pad_di[PAD_SCL] = 1'b0;
      bus.pad_di[PAD_SDA] = 1'b0;
      tick(3);
   endtask

   initial begin
      //                di      fdo     foe     so     e_do    e_oe    e_di    en    si     clk
      func_tbl[0] = '{9'h000, 9'h0A0, 9'h1F0, 2'b00, 9'h0A0, 9'h1F0, 9'h000, 1'b0, 2'b00, 1'b0};
      func_tbl[1] = '{9'h1F2, 9'h155, 9'h1FF, 2'b11, 9'h155, 9'h1FE, 9'h1F2, 1'b0, 2'b00, 1'b0};
      func_tbl[2] = '{9'h0AA, 9'h0FF, 9'h001, 2'b10, 9'h0FF, 9'h000, 9'h0AA, 1'b0, 2'b00, 1'b0};
      scan_tbl[0] = '{9'h011, 9'h000, 9'h1FF, 2'b10, 9'h100, 9'h180, 9'h001, 1'b1, 2'b00, 1'b0};
      scan_tbl[1] = '{9'h063, 9'h07F, 9'h1FF, 2'b01, 9'h0FF, 9'h180, 9'h001, 1'b0, 2'b11, 1'b1};
      scan_tbl[2] = '{9'h00D, 9'h1AA, 9'h000, 2'b00, 9'h02A, 9'h180, 9'h00D, 1'b0, 2'b00, 1'b0};

      bus.pad_di  = 9'h000;
      bus.func_do = 9'h0A0;
      bus.func_oe = 9'h1F0;
      bus.scan_so = 2'b00;
      rstz        = 1'b0;
      #1;
      chk("rst_mode",      9'(bus.mode),      9'd0);
      chk("rst_scan_mode", 9'(bus.scan_mode), 9'd0);
      chk("rst_pad_oe",    bus.pad_oe,        9'h1F0);
      chk("rst_pad_do",    bus.pad_do,        9'h0A0);
      tick(2);
      rstz = 1'b1;
      tick(2);

      for (int i = 0; i < 3; i++) apply_vec($sformatf("func%0d", i), func_tbl[i]);
      bus.pad_di = 9'h000;
      tick(3);

      // Short TST glitch: 3 cycles is one short of the debounce length.
      bus.pad_di[PAD_TST] = 1'b1;
      tick(3);
      bus.pad_di[PAD_TST] = 1'b0;
      tick(8);
      chk("glitch_mode", 9'(bus.mode), 9'd0);

      // Correct key -> SCAN.
      bus.func_oe = 9'h1FF;
      bus.func_do = 9'h000;
      bus.pad_di[PAD_TST] = 1'b1;
      wait_key_entry("enter1");
      chk("key_tst_oe", bus.pad_oe, 9'h1FE);
      shift_key("keyA5", 8'hA5, 2'd1, 2'd2);
      chk("scan_mode_hi", 9'(bus.scan_mode), 9'd1);
      for (int i = 0; i < 3; i++) apply_vec($sformatf("scan%0d", i), scan_tbl[i]);

      // Drop TST in SCAN: back to FUNC DEB+3 cycles later.
      bus.pad_di  = 9'h011;
      bus.func_oe = 9'h0F3;
      bus.func_do = 9'h123;
      drop_tst("scan_exit", 2'd2);
      chk("exit_pad_oe",    bus.pad_oe,        9'h0F2);
      chk("exit_pad_do",    bus.pad_do,        9'h123);
      chk("exit_scan_en",   9'(bus.scan_en),   9'd0);
      chk("exit_scan_mode", 9'(bus.scan_mode), 9'd0);
      bus.pad_di = 9'h000;
      tick(3);

      // Wrong key -> LOCK; SCL rises there are ignored.
      bus.func_oe = 9'h1FF;
      bus.func_do = 9'h0C3;
      bus.pad_di[PAD_TST] = 1'b1;
      wait_key_entry("enter2");
      shift_key("keyA4", 8'hA4, 2'd1, 2'd3);
      bus.pad_di[PAD_GPIO1] = 1'b1;
      #1;
      chk("lock_scan_en",   9'(bus.scan_en),   9'd0);
      chk("lock_scan_mode", 9'(bus.scan_mode), 9'd0);
      chk("lock_pad_oe",    bus.pad_oe,        9'h1FE);
      chk("lock_pad_do",    bus.pad_do,        9'h0C3);
      bus.pad_di[PAD_GPIO1] = 1'b0;
      shift_key("lock_ign", 8'hA5, 2'd3, 2'd3);
      drop_tst("lock_exit", 2'd3);
      tick(3);

      // Async reset in SCAN, then the key must be re-entered.
      bus.pad_di[PAD_TST] = 1'b1;
      wait_key_entry("enter3");
      shift_key("keyA5b", 8'hA5, 2'd1, 2'd2);
      rstz = 1'b0;
      #1;
      chk("arst_mode",      9'(bus.mode),      9'd0);
      chk("arst_scan_mode", 9'(bus.scan_mode), 9'd0);
      chk("arst_pad_oe",    bus.pad_oe,        9'h1FE);
      tick(1);
      rstz = 1'b1;
      wait_key_entry("reenter");
      tick(5);
      chk("reenter_no_scan", 9'(bus.mode), 9'd1);
      shift_key("keyA5c", 8'hA5, 2'd1, 2'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
